// File: rtl/usb_packetizer.sv
// usb_packetizer
//   Buffers fixed-rate signed samples in a small FIFO and frames them into
//   packets for the FT2232H FIFO writer. Each packet is the SYNC byte, an
//   8-bit sequence number, then FRAME_LEN samples sent as two bytes each,
//   big-endian and sign-extended to 16 bits.
//
// Ports
//   clk_i           USB-domain clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   sample_i        signed sample (two's complement, SDW bits)
//   sample_valid_i  write strobe for sample_i; the source cannot be stalled
//   byte_o          byte offered to the USB writer
//   byte_valid_o    byte_o is valid
//   byte_ready_i    writer accepts; a transfer is byte_valid_o & byte_ready_i
//   overflow_o      sticky, set when a sample is dropped on a full FIFO
//   frame_active_o  high from the first header byte until the last byte is taken
module usb_packetizer #(
  parameter int         SDW       = 12,
  parameter int         FRAME_LEN = 1024,
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] SYNC      = 8'hA5
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [SDW-1:0] sample_i,
  input  logic           sample_valid_i,
  output logic [7:0]     byte_o,
  output logic           byte_valid_o,
  input  logic           byte_ready_i,
  output logic           overflow_o,
  output logic           frame_active_o
);

  localparam int         DEPTH    = 2 ** FIFO_AW;
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, SMSB, SLSB} state_t;

  state_t               state_q, state_d;
  logic [SDW-1:0]       mem [DEPTH];
  logic [FIFO_AW:0]     wr_ptr, rd_ptr;
  logic                 full, empty, push, pop, frame_done;
  logic [7:0]           seq_q;
  logic [15:0]          cnt_q;
  logic [15:0]          head_ext;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push     = sample_valid_i && !full;
  assign head_ext = 16'($signed(mem[rd_ptr[FIFO_AW-1:0]]));

  // Sample storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= sample_i;
    end
  end

  // FIFO pointers and the sticky drop flag. Fullness is taken before the
  // edge, so a pop on the same cycle does not rescue a write into a full FIFO.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (sample_valid_i && full) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // State register plus the per-frame sample counter and sequence number.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      seq_q   <= 8'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (frame_done) begin
        cnt_q <= 16'd0;
        seq_q <= seq_q + 8'd1;
      end else if (pop) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Next state and outputs. Outputs decode the registered state and the FIFO
  // head, which is only popped on an accepted LSB, so a stalled byte holds.
  always_comb begin
    state_d        = state_q;
    byte_o         = 8'd0;
    byte_valid_o   = 1'b0;
    pop            = 1'b0;
    frame_done     = 1'b0;
    frame_active_o = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = HDR0;
        end
      end
      HDR0: begin
        byte_o       = SYNC;
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          state_d = HDR1;
        end
      end
      HDR1: begin
        byte_o       = seq_q;
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          state_d = SMSB;
        end
      end
      SMSB: begin
        // Waits indefinitely for the next sample with valid low.
        byte_valid_o = !empty;
        if (!empty) begin
          byte_o = head_ext[15:8];
          if (byte_ready_i) begin
            state_d = SLSB;
          end
        end
      end
      SLSB: begin
        byte_o       = head_ext[7:0];
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          pop = 1'b1;
          if (cnt_q == LAST_IDX) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = SMSB;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_packetizer.sv
// tb_usb_packetizer
//   Scoreboard bench for usb_packetizer with FRAME_LEN = 2, SDW = 12,
//   FIFO_AW = 4. Stimulus pushes the expected byte stream into a queue;
//   a negedge monitor pops and compares every accepted byte and checks that
//   stalled bytes hold.
module tb_usb_packetizer;

  localparam int SDW       = 12;
  localparam int FRAME_LEN = 2;
  localparam int FIFO_AW   = 4;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic [SDW-1:0] sample_i;
  logic           sample_valid_i;
  logic [7:0]     byte_o;
  logic           byte_valid_o;
  logic           byte_ready_i = 1'b0;
  logic           overflow_o;
  logic           frame_active_o;

  int         checks    = 0;
  int         errors    = 0;
  int         readyMode = 1;
  int         modelCnt  = 0;
  logic [7:0] modelSeq  = 8'd0;
  logic [7:0] expQ [$];
  logic       stalled   = 1'b0;
  logic [7:0] heldByte  = 8'd0;

  usb_packetizer #(
    .SDW       (SDW),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_AW   (FIFO_AW),
    .SYNC      (8'hA5)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .byte_ready_i   (byte_ready_i),
    .overflow_o     (overflow_o),
    .frame_active_o (frame_active_o)
  );

  always #5 clk_i = ~clk_i;

  // Ready is driven from one place: held low, held high, or a 50% coin toss.
  always @(posedge clk_i) begin
    #1;
    case (readyMode)
      0:       byte_ready_i = 1'b0;
      1:       byte_ready_i = 1'b1;
      default: byte_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference framing: header before the first sample of each frame,
  // then the sign-extended sample MSB and LSB.
  task automatic expectSample(input logic [SDW-1:0] s);
    logic [15:0] e;
    e = s[SDW-1] ? {4'hF, s} : {4'h0, s};
    if (modelCnt == 0) begin
      expQ.push_back(8'hA5);
      expQ.push_back(modelSeq);
    end
    expQ.push_back(e[15:8]);
    expQ.push_back(e[7:0]);
    modelCnt++;
    if (modelCnt == FRAME_LEN) begin
      modelCnt = 0;
      modelSeq = modelSeq + 8'd1;
    end
  endtask

  // Entered and left just after a rising edge; the write happens on the
  // edge inside, so back-to-back calls write on consecutive cycles.
  task automatic applyStimulus(input logic [SDW-1:0] s, input bit kept);
    sample_valid_i = 1'b1;
    sample_i       = s;
    if (kept) begin
      expectSample(s);
    end
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    checkOutput("drain_done", 32'(expQ.size()), 32'd0);
    waitCycles(3);
  endtask

  // Monitor: compare each accepted byte against the queue head, and make
  // sure a byte offered without ready is still offered one cycle later.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("hold_valid", {31'd0, byte_valid_o}, 32'd1);
        checkOutput("hold_byte", {24'd0, byte_o}, {24'd0, heldByte});
      end
      if (byte_valid_o && byte_ready_i) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got %0h expected none", byte_o);
        end else begin
          checkOutput("stream_byte", {24'd0, byte_o}, {24'd0, expQ.pop_front()});
        end
        stalled = 1'b0;
      end else if (byte_valid_o) begin
        stalled  = 1'b1;
        heldByte = byte_o;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  logic [SDW-1:0] specials [6] = '{12'h800, 12'h7FF, 12'h000, 12'hFFF, 12'h001, 12'h123};
  logic [SDW-1:0] slowVals [4] = '{12'h321, 12'hC00, 12'h0FF, 12'h8A1};

  initial begin
    rst_n_i        = 1'b0;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    readyMode      = 1;
    waitCycles(3);
    checkOutput("reset_byte", {24'd0, byte_o}, 32'd0);
    checkOutput("reset_valid", {31'd0, byte_valid_o}, 32'd0);
    checkOutput("reset_active", {31'd0, frame_active_o}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow_o}, 32'd0);
    rst_n_i = 1'b1;
    waitCycles(2);

    $display("[TB] basic frame");
    applyStimulus(12'h123, 1'b1);
    applyStimulus(12'hFFF, 1'b1);
    checkOutput("latency_valid", {31'd0, byte_valid_o}, 32'd1);
    checkOutput("latency_sync", {24'd0, byte_o}, 32'hA5);
    checkOutput("latency_active", {31'd0, frame_active_o}, 32'd1);
    drain();
    checkOutput("t1_active_low", {31'd0, frame_active_o}, 32'd0);
    checkOutput("t1_overflow", {31'd0, overflow_o}, 32'd0);

    $display("[TB] back-to-back frames");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(12'(12'h100 * i + 12'h05), 1'b1);
    end
    drain();

    $display("[TB] random ready, 1000 samples");
    readyMode = 2;
    for (int i = 0; i < 1000; i++) begin
      if (i < 6) begin
        applyStimulus(specials[i], 1'b1);
      end else begin
        applyStimulus(12'($urandom_range(0, 4095)), 1'b1);
      end
      waitCycles(8);
    end
    drain();
    readyMode = 1;
    checkOutput("t3_no_overflow", {31'd0, overflow_o}, 32'd0);

    $display("[TB] overflow with ready low");
    readyMode = 0;
    waitCycles(3);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(12'(12'h40 + i), i < 16);
      if (i == 15) begin
        checkOutput("t4_no_overflow_at_16", {31'd0, overflow_o}, 32'd0);
      end
    end
    checkOutput("t4_overflow_set", {31'd0, overflow_o}, 32'd1);
    waitCycles(5);
    checkOutput("t4_overflow_held", {31'd0, overflow_o}, 32'd1);
    readyMode = 1;
    drain();
    waitCycles(10);
    checkOutput("t4_no_extra_bytes", {31'd0, byte_valid_o}, 32'd0);
    checkOutput("t4_overflow_sticky", {31'd0, overflow_o}, 32'd1);

    $display("[TB] slow source, SMSB wait");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(slowVals[k], 1'b1);
      if (k % 2 == 0) begin
        waitCycles(5);
        checkOutput("t5_wait_valid_low", {31'd0, byte_valid_o}, 32'd0);
        checkOutput("t5_wait_active", {31'd0, frame_active_o}, 32'd1);
        waitCycles(2);
      end else begin
        waitCycles(7);
      end
    end
    drain();

    $display("[TB] reset mid-frame");
    applyStimulus(12'h456, 1'b1);
    waitCycles(4);
    #1;
    rst_n_i = 1'b0;
    #1;
    checkOutput("t6_byte", {24'd0, byte_o}, 32'd0);
    checkOutput("t6_valid", {31'd0, byte_valid_o}, 32'd0);
    checkOutput("t6_active", {31'd0, frame_active_o}, 32'd0);
    checkOutput("t6_overflow", {31'd0, overflow_o}, 32'd0);
    expQ.delete();
    modelCnt = 0;
    modelSeq = 8'd0;
    waitCycles(2);
    rst_n_i = 1'b1;
    waitCycles(2);
    applyStimulus(12'h9AB, 1'b1);
    applyStimulus(12'h00C, 1'b1);
    drain();

    checkOutput("end_queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
